// File: rtl/seg7_bcd_reader.sv
// ---------------------------------------------------------------------------
// seg7_bcd_reader
//
// Watches a 7-segment display drive and turns stable, legal digit patterns
// back into BCD. A pattern must be seen unchanged on STABLE_CYCLES
// consecutive sampling edges before it is decoded. A legal digit is offered
// on a valid/ready output. An illegal pattern raises a one-cycle err pulse
// and bumps a saturating error counter. Once a pattern has been handled it
// is not reported again until it changes or sampling is interrupted.
//
// Parameters
//   STABLE_CYCLES  : matching samples needed before decoding (1..15)
//   SEG_ACTIVE_LOW : 1 = seg7 is inverted before use
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   seg7[6:0]  in   segment pattern {g,f,e,d,c,b,a}
//   seg_valid  in   seg7 is sampled only when this is 1
//   bcd[3:0]   out  decoded digit (registered)
//   bcd_valid  out  bcd holds an undelivered digit
//   bcd_ready  in   consumer accepts bcd when bcd_valid is also 1
//   err        out  one-cycle pulse for a stable illegal pattern
//   err_count  out  saturating count of err pulses
// ---------------------------------------------------------------------------
module seg7_bcd_reader #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg7,
    input  logic       seg_valid,
    output logic [3:0] bcd,
    output logic       bcd_valid,
    input  logic       bcd_ready,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        TRACK       = 2'd0,
        EMIT        = 2'd1,
        WAIT_CHANGE = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [6:0] prev, prev_next;
    logic [3:0] cnt, cnt_next;
    logic [6:0] last, last_next;
    logic [3:0] bcd_next;
    logic       bcd_valid_next;
    logic       err_next;
    logic [7:0] err_count_next;
    logic [6:0] pattern;
    logic [4:0] decoded;

    // Returns {legal, digit}; anything outside the ten digit shapes is illegal.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = {1'b1, 4'd0};
            7'h06:   r = {1'b1, 4'd1};
            7'h5B:   r = {1'b1, 4'd2};
            7'h4F:   r = {1'b1, 4'd3};
            7'h66:   r = {1'b1, 4'd4};
            7'h6D:   r = {1'b1, 4'd5};
            7'h7D:   r = {1'b1, 4'd6};
            7'h07:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h6F:   r = {1'b1, 4'd9};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    // All state is registered here; reset wins over every other event,
    // including a handshake or a pending digit on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TRACK;
            prev      <= 7'd0;
            cnt       <= 4'd0;
            last      <= 7'd0;
            bcd       <= 4'd0;
            bcd_valid <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state     <= state_next;
            prev      <= prev_next;
            cnt       <= cnt_next;
            last      <= last_next;
            bcd       <= bcd_next;
            bcd_valid <= bcd_valid_next;
            err       <= err_next;
            err_count <= err_count_next;
        end
    end

    // Next-state logic. The stability decision uses the count after this
    // edge's update, so a digit appears STABLE_CYCLES-1 edges after the
    // first matching sample (on the very first sample when STABLE_CYCLES=1).
    always_comb begin
        state_next     = state;
        prev_next      = prev;
        cnt_next       = cnt;
        last_next      = last;
        bcd_next       = bcd;
        bcd_valid_next = bcd_valid;
        err_next       = 1'b0;
        err_count_next = err_count;
        decoded        = 5'd0;
        pattern        = SEG_ACTIVE_LOW ? ~seg7 : seg7;

        case (state)
            TRACK: begin
                if (seg_valid) begin
                    if (pattern == prev) begin
                        if (cnt != STABLE) begin
                            cnt_next = cnt + 4'd1;
                        end
                    end else begin
                        prev_next = pattern;
                        cnt_next  = 4'd1;
                    end
                end else begin
                    cnt_next = 4'd0;
                end

                if (seg_valid && (cnt_next == STABLE)) begin
                    last_next = prev_next;
                    decoded   = decode_seg(prev_next);
                    if (decoded[4]) begin
                        bcd_next       = decoded[3:0];
                        bcd_valid_next = 1'b1;
                        state_next     = EMIT;
                    end else begin
                        err_next = 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count_next = err_count + 8'd1;
                        end
                        state_next = WAIT_CHANGE;
                    end
                end
            end

            // Segment input is ignored while a digit waits for the consumer.
            EMIT: begin
                if (bcd_ready) begin
                    bcd_valid_next = 1'b0;
                    state_next     = WAIT_CHANGE;
                end
            end

            // A held pattern stays here so it is reported only once; a gap in
            // seg_valid re-arms tracking of the same pattern.
            WAIT_CHANGE: begin
                if (seg_valid) begin
                    if (pattern != last) begin
                        state_next = TRACK;
                        prev_next  = pattern;
                        cnt_next   = 4'd1;
                    end
                end else begin
                    state_next = TRACK;
                    cnt_next   = 4'd0;
                end
            end

            default: begin
                state_next = TRACK;
            end
        endcase
    end

endmodule

// File: tb/tb_seg7_bcd_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_bcd_reader
//
// Drives two instances of seg7_bcd_reader from one stimulus stream:
//   dut_a : default build (STABLE_CYCLES=4, active-high segments)
//   dut_b : STABLE_CYCLES=1, active-low segments (fed the inverted pattern)
// Both are followed cycle by cycle by a behavioural model that thinks in
// terms of "run of identical samples", "digit pending" and "blocked until
// the pattern changes". Directed vectors with hand-derived expectations
// cover the documented scenarios, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_seg7_bcd_reader;

    logic       clk;
    logic       rst;
    logic       seg_valid;
    logic       bcd_ready;
    logic [6:0] seg7_a;
    logic [6:0] seg7_b;
    logic [3:0] bcd_a, bcd_b;
    logic       bcd_valid_a, bcd_valid_b;
    logic       err_a, err_b;
    logic [7:0] err_count_a, err_count_b;

    int compared;
    int mismatched;

    assign seg7_b = ~seg7_a;

    seg7_bcd_reader #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .seg7(seg7_a), .seg_valid(seg_valid),
        .bcd(bcd_a), .bcd_valid(bcd_valid_a), .bcd_ready(bcd_ready),
        .err(err_a), .err_count(err_count_a)
    );

    seg7_bcd_reader #(.STABLE_CYCLES(1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .seg7(seg7_b), .seg_valid(seg_valid),
        .bcd(bcd_b), .bcd_valid(bcd_valid_b), .bcd_ready(bcd_ready),
        .err(err_b), .err_count(err_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    typedef struct {
        bit         pending;
        bit         blocked;
        logic [6:0] run_pat;
        int         run_len;
        logic [6:0] last;
        int         bcd;
        bit         err;
        int         err_count;
    } model_t;

    model_t ma, mb;

    logic [6:0] digit_pat [10];

    function automatic int find_digit(input logic [6:0] p);
        for (int d = 0; d < 10; d++) begin
            if (digit_pat[d] == p) return d;
        end
        return -1;
    endfunction

    function automatic model_t model_reset();
        model_t n;
        n.pending   = 0;
        n.blocked   = 0;
        n.run_pat   = 7'd0;
        n.run_len   = 0;
        n.last      = 7'd0;
        n.bcd       = 0;
        n.err       = 0;
        n.err_count = 0;
        return n;
    endfunction

    function automatic model_t model_step(input model_t m, input int stable,
                                          input bit r, input bit v,
                                          input logic [6:0] p, input bit rdy);
        model_t n;
        int     d;
        n = m;
        n.err = 0;
        if (r) begin
            n = model_reset();
        end else if (m.pending) begin
            if (rdy) begin
                n.pending = 0;
                n.blocked = 1;
            end
        end else if (m.blocked) begin
            if (!v) begin
                n.blocked = 0;
                n.run_len = 0;
            end else if (p != m.last) begin
                n.blocked = 0;
                n.run_pat = p;
                n.run_len = 1;
            end
        end else begin
            if (!v) begin
                n.run_len = 0;
            end else begin
                if (p == m.run_pat) n.run_len = m.run_len + 1;
                else begin
                    n.run_pat = p;
                    n.run_len = 1;
                end
                if (n.run_len >= stable) begin
                    n.run_len = stable;
                    n.last    = n.run_pat;
                    d = find_digit(n.run_pat);
                    if (d >= 0) begin
                        n.bcd     = d;
                        n.pending = 1;
                    end else begin
                        n.err       = 1;
                        n.err_count = (m.err_count < 255) ? m.err_count + 1 : 255;
                        n.blocked   = 1;
                    end
                end
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge: advance the models with the inputs present at the
    // edge, then compare both DUTs against them shortly after.
    task automatic tick();
        @(posedge clk);
        ma = model_step(ma, 4, rst, seg_valid, seg7_a, bcd_ready);
        mb = model_step(mb, 1, rst, seg_valid, seg7_a, bcd_ready);
        #1;
        checkOutput("model_a bcd", bcd_a, ma.bcd);
        checkOutput("model_a bcd_valid", bcd_valid_a, ma.pending);
        checkOutput("model_a err", err_a, ma.err);
        checkOutput("model_a err_count", err_count_a, ma.err_count);
        checkOutput("model_b bcd", bcd_b, mb.bcd);
        checkOutput("model_b bcd_valid", bcd_valid_b, mb.pending);
        checkOutput("model_b err", err_b, mb.err);
        checkOutput("model_b err_count", err_count_b, mb.err_count);
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [6:0] p, input bit rdy);
        rst       = r;
        seg_valid = v;
        seg7_a    = p;
        bcd_ready = rdy;
        tick();
    endtask

    // Directed vector: inputs held for reps edges, expected dut_a outputs
    // after each of those edges.
    typedef struct {
        bit         r;
        bit         v;
        logic [6:0] p;
        bit         rdy;
        int         reps;
        int         bcd;
        bit         vld;
        bit         err;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit r, input bit v, input logic [6:0] p, input bit rdy,
                           input int reps, input int bcd, input bit vld, input bit err,
                           input int cnt);
        vec_t e;
        e.r = r; e.v = v; e.p = p; e.rdy = rdy; e.reps = reps;
        e.bcd = bcd; e.vld = vld; e.err = err; e.cnt = cnt;
        vecs.push_back(e);
    endtask

    logic [6:0] seq_pat [6];
    logic [6:0] rand_pat [13];
    logic [6:0] cur;

    initial begin
        compared   = 0;
        mismatched = 0;
        digit_pat  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        seq_pat    = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};
        rand_pat   = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                       7'h49, 7'h00, 7'h7E};
        ma = model_reset();
        mb = model_reset();
        rst = 1'b1; seg_valid = 1'b0; seg7_a = 7'h00; bcd_ready = 1'b0;

        // Reset, then digit 2 held, delivered after a long wait.
        add_vec(1, 0, 7'h00, 0, 1,  0, 0, 0, 0);
        add_vec(0, 1, 7'h5B, 0, 3,  0, 0, 0, 0);
        add_vec(0, 1, 7'h5B, 0, 1,  2, 1, 0, 0);
        add_vec(0, 1, 7'h5B, 0, 10, 2, 1, 0, 0);
        add_vec(0, 1, 7'h5B, 1, 1,  2, 0, 0, 0);
        add_vec(0, 1, 7'h5B, 1, 3,  2, 0, 0, 0);
        // Digits 0..5 in order, one handshake each.
        for (int d = 0; d < 6; d++) begin
            add_vec(0, 1, seq_pat[d], 0, 3, (d == 0) ? 2 : d - 1, 0, 0, 0);
            add_vec(0, 1, seq_pat[d], 0, 1, d, 1, 0, 0);
            add_vec(0, 1, seq_pat[d], 1, 1, d, 0, 0, 0);
        end
        // Short-lived 0x6D is discarded; 0x7D decodes to 6.
        add_vec(0, 0, 7'h00, 0, 1, 5, 0, 0, 0);
        add_vec(0, 1, 7'h6D, 0, 3, 5, 0, 0, 0);
        add_vec(0, 1, 7'h7D, 0, 3, 5, 0, 0, 0);
        add_vec(0, 1, 7'h7D, 0, 1, 6, 1, 0, 0);
        add_vec(0, 1, 7'h7D, 1, 1, 6, 0, 0, 0);
        // Illegal 0x49: single err pulse, no repeat while held.
        add_vec(0, 1, 7'h49, 0, 3,  6, 0, 0, 0);
        add_vec(0, 1, 7'h49, 0, 1,  6, 0, 1, 1);
        add_vec(0, 1, 7'h49, 0, 20, 6, 0, 0, 1);
        // 0x07 held 30 edges, handshake on edge 6, then re-armed by a gap.
        add_vec(0, 1, 7'h07, 0, 3,  6, 0, 0, 1);
        add_vec(0, 1, 7'h07, 0, 2,  7, 1, 0, 1);
        add_vec(0, 1, 7'h07, 1, 1,  7, 0, 0, 1);
        add_vec(0, 1, 7'h07, 0, 24, 7, 0, 0, 1);
        add_vec(0, 0, 7'h07, 0, 1,  7, 0, 0, 1);
        add_vec(0, 1, 7'h07, 0, 3,  7, 0, 0, 1);
        add_vec(0, 1, 7'h07, 0, 1,  7, 1, 0, 1);
        // Reset beats a same-edge handshake; sampling resumes immediately.
        add_vec(1, 1, 7'h07, 1, 1,  0, 0, 0, 0);
        add_vec(0, 1, 7'h4F, 0, 3,  0, 0, 0, 0);
        add_vec(0, 1, 7'h4F, 0, 1,  3, 1, 0, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                applyStimulus(vecs[i].r, vecs[i].v, vecs[i].p, vecs[i].rdy);
                checkOutput($sformatf("vec%0d.%0d bcd", i, k), bcd_a, vecs[i].bcd);
                checkOutput($sformatf("vec%0d.%0d bcd_valid", i, k), bcd_valid_a, vecs[i].vld);
                checkOutput($sformatf("vec%0d.%0d err", i, k), err_a, vecs[i].err);
                checkOutput($sformatf("vec%0d.%0d err_count", i, k), err_count_a, vecs[i].cnt);
            end
        end

        // Error counter saturation: alternate two illegal patterns.
        applyStimulus(0, 1, 7'h4F, 1);
        for (int i = 0; i < 260; i++) begin
            for (int k = 0; k < 4; k++) applyStimulus(0, 1, (i % 2) ? 7'h49 : 7'h4A, 0);
            checkOutput($sformatf("sat%0d err_count", i), err_count_a, (i + 1 < 255) ? i + 1 : 255);
        end

        // Single-sample build with inverted segments: 0x7F gives 8 at once.
        applyStimulus(1, 0, 7'h00, 0);
        checkOutput("b reset bcd_valid", bcd_valid_b, 0);
        checkOutput("b reset err_count", err_count_b, 0);
        applyStimulus(0, 1, 7'h7F, 0);
        checkOutput("b first-edge bcd", bcd_b, 8);
        checkOutput("b first-edge bcd_valid", bcd_valid_b, 1);

        // Randomized traffic against the model.
        cur = 7'h3F;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 9) < 2) cur = rand_pat[$urandom_range(0, 12)];
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                          cur, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg7_bcd_reader.md
SEG7_BCD_READER -- requirements
Module: seg7_bcd_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive matching samples needed before a pattern is decoded (legal 1..15).
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 0; when 1, seg7 is inverted before any comparison or decoding.
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port seg7  input  7  segment pattern, bit order {g,f,e,d,c,b,a}, active-high after optional inversion.
REQ-006 SHALL have port seg_valid  input  1  seg7 is sampled only on edges where seg_valid=1.
REQ-007 SHALL have port bcd  output  4  decoded digit, registered.
REQ-008 SHALL have port bcd_valid  output  1  bcd holds an undelivered digit.
REQ-009 SHALL have port bcd_ready  input  1  consumer accepts bcd on an edge where bcd_valid=1 and bcd_ready=1.
REQ-010 SHALL have port err  output  1  one-cycle pulse when a stable pattern is not a legal digit.
REQ-011 SHALL have port err_count  output  8  saturating count of err pulses.

Function
REQ-012 SHALL decode only these patterns (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; every other pattern is illegal.
REQ-013 SHALL implement states TRACK, EMIT and WAIT_CHANGE, plus internal regs prev[6:0], cnt[3:0] and last[6:0].
REQ-014 TRACK, seg_valid=1, seg7==prev: cnt increments, saturating at STABLE_CYCLES.
REQ-015 TRACK, seg_valid=1, seg7!=prev: prev<=seg7, cnt<=1.
REQ-016 TRACK, seg_valid=0: cnt<=0, prev unchanged.
REQ-017 Once cnt would reach STABLE_CYCLES (after the update above), the same edge SHALL load last<=prev.
REQ-018 On that edge, a legal pattern SHALL set bcd<=digit and bcd_valid<=1, and move to EMIT.
REQ-019 On that edge, an illegal pattern SHALL set err<=1 for exactly one cycle, increment err_count (saturating at 255), leave bcd unchanged, and move to WAIT_CHANGE.
REQ-020 Latency: a pattern held with seg_valid=1 from edge k SHALL give bcd_valid=1 after edge k+STABLE_CYCLES-1; with STABLE_CYCLES=1 that is the first sampling edge.
REQ-021 EMIT: bcd and bcd_valid SHALL hold unchanged until handshake; seg7 and seg_valid are ignored.
REQ-022 EMIT handshake edge (bcd_ready=1): bcd_valid<=0, bcd retains value, move to WAIT_CHANGE.
REQ-023 bcd_ready while bcd_valid=0 SHALL have no effect.
REQ-024 WAIT_CHANGE, seg_valid=1, seg7==last: no state change, so a held pattern is emitted once only.
REQ-025 WAIT_CHANGE, seg_valid=1, seg7!=last: move to TRACK, prev<=seg7, cnt<=1.
REQ-026 WAIT_CHANGE, seg_valid=0: move to TRACK, cnt<=0; the same pattern may then be re-emitted after it is stable again.
REQ-027 A pattern that changes before cnt reaches STABLE_CYCLES SHALL produce no output and no err.
REQ-028 err SHALL be 0 on every edge other than those in REQ-019.

Reset
REQ-029 rst=1 on an edge SHALL force: state TRACK, prev=0, cnt=0, last=0, bcd=0, bcd_valid=0, err=0, err_count=0.
REQ-030 Reset SHALL take priority over every other event, including a handshake on the same edge and reset during EMIT, where an undelivered digit is discarded.
REQ-031 After rst falls, sampling resumes on the next edge, with no added dead cycles.

Verification
REQ-032 Default params: seg_valid=1, seg7=0x5B for 4 edges, bcd_ready=0 -> bcd_valid=1 and bcd=2 after edge 4; both hold 10 cycles; bcd_ready=1 for 1 edge -> bcd_valid=0 next, bcd stays 2.
REQ-033 Sequence 0x3F,0x06,0x5B,0x4F,0x66,0x6D, each held 4 edges then bcd_ready pulsed -> bcd outputs 0..5 in order, exactly one bcd_valid per digit.
REQ-034 seg7=0x6D for 3 edges then 0x7D for 4 edges -> no output for 0x6D; bcd=6 appears 4 edges after the 0x7D start.
REQ-035 seg7=0x49 held 4 edges -> err=1 for one cycle, err_count=1, bcd_valid stays 0; keep 0x49 another 20 edges -> no further err.
REQ-036 seg7=0x07 held 30 edges, handshake at edge 6 -> exactly one digit 7; then seg_valid=0 for 1 edge and 0x07 for 4 edges -> second digit 7.
REQ-037 rst=1 while bcd_valid=1 with bcd_ready=1 on the same edge -> bcd=0, bcd_valid=0, err_count=0 next cycle; STABLE_CYCLES=1 build with 0x7F for 1 edge -> bcd=8 after that edge.
